// File: rtl/memory_stall_ctrl.sv
// memory_stall_ctrl: issues one load/store from the memory stage to a
// ready/valid memory port. It holds the pipeline with StallMemReq until the
// memory answers, and presents the raw read word on ReadDataM.
// Optional feature macro: MEM_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYCLES
// cycles and a sticky MemError flag. Without it, BUSY waits indefinitely.
module memory_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemReady,
    input  logic [31:0] MemRdata,
    output logic        MemValid,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    output logic [3:0]  MemBe,
    output logic        StallMemReq,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        MemError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;

    // Request fields captured when the access is accepted in IDLE.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;

    logic [31:0] rdata_q;
    logic        misalign_q;

    logic        misalign_in;
    logic        req_ok;
    logic        latch_en;
    logic        capture;
    logic        timeout_hit;

    // Half must sit on an even byte, word (and reserved size) on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Byte-lane enables for an aligned access; reserved size behaves as word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    assign misalign_in = is_misaligned(MemSizeM, ALUResultM[1:0]);
    assign req_ok      = MemReqM && !misalign_in;

    // Memory-side outputs come only from the latched copy, so they cannot
    // move while BUSY even if the pipeline inputs change underneath.
    assign MemWe     = we_q;
    assign MemAddr   = {addr_q[31:2], 2'b00};
    assign MemWdata  = wdata_q << {addr_q[1:0], 3'b000};
    assign MemBe     = byte_en(size_q, addr_q[1:0]);
    assign ReadDataM = rdata_q;
    assign MisalignM = misalign_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] busy_cnt;
    logic       err_q;

    // The watchdog fires on the last allowed BUSY cycle if memory still has not answered.
    assign timeout_hit = (state == BUSY) && !MemReady && (busy_cnt == TIMEOUT_LIM);
    assign MemError    = err_q;

    // Count consecutive BUSY cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            busy_cnt <= 8'd0;
        end else begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end

    // Sticky error: once a timeout happens it stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign MemError       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE always falls back to IDLE so a
    // still-asserted MemReqM cannot re-issue the same instruction.
    always_comb begin
        state_nxt   = state;
        StallMemReq = 1'b0;
        MemValid    = 1'b0;
        latch_en    = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    StallMemReq = 1'b1;
                    latch_en    = 1'b1;
                    state_nxt   = BUSY;
                end
            end
            BUSY: begin
                MemValid    = 1'b1;
                StallMemReq = 1'b1;
                if (MemReady) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= ALUResultM;
            wdata_q <= WriteDataM;
            size_q  <= MemSizeM;
            we_q    <= MemWriteM;
        end
    end

    // Read word register: loads capture on completion, a timeout clears it,
    // stores leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (capture && !we_q) begin
            rdata_q <= MemRdata;
        end else if (timeout_hit) begin
            rdata_q <= 32'd0;
        end
    end

    // One-cycle misalignment pulse for a rejected request seen in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state == IDLE) && MemReqM && misalign_in;
        end
    end

endmodule

// File: tb/tb_memory_stall_ctrl.sv
// Self-checking bench for memory_stall_ctrl: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_memory_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        MemReqM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemReady;
    logic [31:0] MemRdata;
    logic        MemValid;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemBe;
    logic        StallMemReq;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        MemError;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] exp_rdata;
    logic        exp_err;

`ifdef MEM_TIMEOUT_EN
    localparam int MAXDLY = 3;
`else
    localparam int MAXDLY = 6;
`endif

    memory_stall_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .MemSizeM(MemSizeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .MemReady(MemReady), .MemRdata(MemRdata), .MemValid(MemValid),
        .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemBe(MemBe),
        .StallMemReq(StallMemReq), .ReadDataM(ReadDataM), .MisalignM(MisalignM),
        .MemError(MemError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_fields();
        ALUResultM = $urandom;
        WriteDataM = $urandom;
        MemSizeM   = 2'($urandom);
        MemWriteM  = 1'($urandom);
        MemRdata   = $urandom;
    endtask

    // Idle cycles with no request: nothing issued, stray MemReady ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MemReqM  = 1'b0;
            MemReady = 1'($urandom);
            scramble_fields();
            #1;
            check_val("idle_stall", 32'(StallMemReq), 32'd0);
            check_val("idle_valid", 32'(MemValid), 32'd0);
            check_val("idle_rdata", ReadDataM, exp_rdata);
        end
    endtask

    // One full transaction starting in IDLE; memory answers after dly extra cycles.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
        int          off;
        int          nb;
        int          stalls;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        off = int'(addr % 4);
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (off % nb) != 0;
        be  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) be[i] = 1'b1;
        end
        wd     = wdata << (8 * off);
        stalls = 0;

        @(negedge clk);
        MemReqM    = 1'b1;
        MemWriteM  = we;
        MemSizeM   = size;
        ALUResultM = addr;
        WriteDataM = wdata;
        MemReady   = 1'($urandom);
        MemRdata   = $urandom;
        #1;
        stalls += int'(StallMemReq);
        check_val("req_valid", 32'(MemValid), 32'd0);
        check_val("req_stall", 32'(StallMemReq), 32'(!mis));

        if (mis) begin
            @(negedge clk);
            MemReqM  = 1'b0;
            MemReady = 1'($urandom);
            scramble_fields();
            #1;
            check_val("mis_pulse", 32'(MisalignM), 32'd1);
            check_val("mis_valid", 32'(MemValid), 32'd0);
            check_val("mis_stall", 32'(StallMemReq), 32'd0);
            @(negedge clk);
            MemReady = 1'($urandom);
            #1;
            check_val("mis_end", 32'(MisalignM), 32'd0);
            check_val("mis_valid2", 32'(MemValid), 32'd0);
            check_val("mis_rdata", ReadDataM, exp_rdata);
            return;
        end

        for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            scramble_fields();
            MemReady = (k == dly);
            if (k == dly) MemRdata = rdata;
            #1;
            stalls += int'(StallMemReq);
            check_val("busy_valid", 32'(MemValid), 32'd1);
            check_val("busy_addr", MemAddr, {addr[31:2], 2'b00});
            check_val("busy_be", 32'(MemBe), 32'(be));
            check_val("busy_wdata", MemWdata, wd);
            check_val("busy_we", 32'(MemWe), 32'(we));
            check_val("busy_misal", 32'(MisalignM), 32'd0);
        end

        @(negedge clk);
        MemReady = 1'($urandom);
        MemRdata = $urandom;
        #1;
        stalls += int'(StallMemReq);
        if (!we) exp_rdata = rdata;
        check_val("done_valid", 32'(MemValid), 32'd0);
        check_val("done_rdata", ReadDataM, exp_rdata);
        check_val("stall_cycles", 32'(stalls), 32'(dly + 2));
        check_val("done_err", 32'(MemError), 32'(exp_err));
    endtask

    // Reset asserted at the end of the second BUSY cycle, then a late MemReady.
    task automatic reset_mid_busy();
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'd2;
        ALUResultM = 32'h0000_0040; MemReady = 1'b0;
        #1;
        check_val("rb_req_stall", 32'(StallMemReq), 32'd1);
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        check_val("rb_busy1", 32'(MemValid), 32'd1);
        @(negedge clk);
        MemReady = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rb_busy2", 32'(MemValid), 32'd1);
        @(negedge clk);
        rst = 1'b0; MemReqM = 1'b0; MemReady = 1'b1; MemRdata = 32'h1234_5678;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        #1;
        check_val("rb_valid", 32'(MemValid), 32'd0);
        check_val("rb_stall", 32'(StallMemReq), 32'd0);
        check_val("rb_rdata", ReadDataM, 32'd0);
        check_val("rb_err", 32'(MemError), 32'd0);
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        check_val("rb_valid2", 32'(MemValid), 32'd0);
        check_val("rb_rdata2", ReadDataM, 32'd0);
    endtask

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: four BUSY cycles, then DONE with an error.
    task automatic timeout_case();
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'd2;
        ALUResultM = 32'h0000_0080; MemReady = 1'b0;
        #1;
        check_val("to_req", 32'(StallMemReq), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            MemReady = 1'b0;
            #1;
            check_val("to_busy", 32'(MemValid), 32'd1);
        end
        @(negedge clk);
        MemReady = 1'b0;
        exp_rdata = 32'd0;
        exp_err   = 1'b1;
        #1;
        check_val("to_done_valid", 32'(MemValid), 32'd0);
        check_val("to_done_stall", 32'(StallMemReq), 32'd0);
        check_val("to_rdata", ReadDataM, 32'd0);
        check_val("to_err", 32'(MemError), 32'd1);
    endtask
`endif

    initial begin
        rst = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; MemSizeM = 2'd0;
        ALUResultM = 32'd0; WriteDataM = 32'd0; MemReady = 1'b0; MemRdata = 32'd0;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_valid", 32'(MemValid), 32'd0);
        check_val("rst_stall", 32'(StallMemReq), 32'd0);
        check_val("rst_rdata", ReadDataM, 32'd0);
        check_val("rst_misal", 32'(MisalignM), 32'd0);
        check_val("rst_err", 32'(MemError), 32'd0);
        check_val("rst_addr", MemAddr, 32'd0);
        check_val("rst_we", 32'(MemWe), 32'd0);
        check_val("rst_wdata", MemWdata, 32'd0);

        // Load word, immediate answer.
        run_txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        // Store byte to the top lane, answer delayed by three cycles.
        run_txn(1'b1, 2'd0, 32'h0000_0203, 32'h0000_00AB, 32'h5555_5555, 3);
        // Misaligned half.
        run_txn(1'b0, 2'd1, 32'h0000_0101, 32'h0, 32'h0, 0);
        // Back-to-back loads.
        run_txn(1'b0, 2'd1, 32'h0000_0302, 32'h0, 32'hCAFE_F00D, 1);
        run_txn(1'b0, 2'd3, 32'h0000_0404, 32'h0, 32'h0BAD_CAFE, 0);
        idle_cycles(3);

`ifdef MEM_TIMEOUT_EN
        timeout_case();
        run_txn(1'b0, 2'd2, 32'h0000_0500, 32'h0, 32'h7777_0001, 2);
`endif

        reset_mid_busy();

        for (int t = 0; t < 80; t++) begin
            run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, MAXDLY)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_stall_ctrl.md
MEMORY_STALL_CTRL -- requirements
Module: memory_stall_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum BUSY cycles before abort; only used with MEM_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port MemReqM, input, 1, meaning a load or store is valid in the memory stage.
REQ-005 SHALL have port MemWriteM, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port MemSizeM, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved, treated as word.
REQ-007 SHALL have port ALUResultM, input, 32, the byte address.
REQ-008 SHALL have port WriteDataM, input, 32, the store data, right-aligned.
REQ-009 SHALL have port MemReady, input, 1, the memory-side completion strobe.
REQ-010 SHALL have port MemRdata, input, 32, the memory read word; valid when MemReady is high.
REQ-011 SHALL have port MemValid, output, 1, the request to memory.
REQ-012 SHALL have port MemWe, output, 1, the latched write enable.
REQ-013 SHALL have port MemAddr, output, 32, the latched address with bits [1:0] forced to 00.
REQ-014 SHALL have port MemWdata, output, 32, the store data shifted to its byte lane.
REQ-015 SHALL have port MemBe, output, 4, the byte enables.
REQ-016 SHALL have port StallMemReq, output, 1, the stall request to the hazard unit.
REQ-017 SHALL have port ReadDataM, output, 32, the registered raw read word.
REQ-018 SHALL have port MisalignM, output, 1, a one-cycle misaligned-access pulse.
REQ-019 SHALL have port MemError, output, 1, a sticky timeout flag.

Function
REQ-020 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-021 IDLE: StallMemReq SHALL equal MemReqM AND NOT misaligned, combinationally; on that condition the block latches the address, data, size and MemWriteM, and moves to BUSY.
REQ-022 BUSY: MemValid=1, StallMemReq=1; when MemReady=1, ReadDataM SHALL capture MemRdata (loads only; stores leave it unchanged) and the FSM moves to DONE.
REQ-023 DONE: StallMemReq=0 and MemValid=0; the next state SHALL be IDLE unconditionally, so the same instruction never re-issues.
REQ-024 Minimum latency SHALL be 2 stall cycles (IDLE request cycle and BUSY with MemReady high); each extra cycle of MemReady low adds one stall cycle.
REQ-025 MemBe: byte = 0001 shifted left by addr[1:0]; half = 0011 shifted left by addr[1]*2; word = 1111.
REQ-026 MemWdata SHALL equal WriteDataM shifted left by 8*addr[1:0].
REQ-027 Misalignment SHALL be defined as: half with addr[0]=1, or word with addr[1:0]≠00.
REQ-028 On a misaligned access in IDLE, MisalignM SHALL pulse high for exactly one cycle (registered), no request is issued, and StallMemReq stays 0.
REQ-029 MemReady while in IDLE or DONE SHALL be ignored.
REQ-030 MemValid, MemWe, MemAddr, MemWdata and MemBe SHALL be held stable throughout BUSY.

Reset
REQ-031 When rst is high at a clock edge: state=IDLE, ReadDataM=0, latched fields=0, MisalignM=0, MemError=0, and the timeout counter=0.
REQ-032 Reset during BUSY SHALL abort the access; MemValid is low from the cycle after the reset edge, and a late MemReady is ignored.

Configuration
REQ-033 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL count BUSY cycles; on reaching TIMEOUT_CYCLES without MemReady, the FSM moves to DONE, ReadDataM is set to 0, and MemError is set and held until rst.
REQ-034 Without MEM_TIMEOUT_EN, no counter SHALL exist, MemError is tied to 0, and BUSY waits indefinitely.

Verification
REQ-035 Load word at 0x100, MemReady high in the first BUSY cycle, MemRdata=0xDEADBEEF -> StallMemReq high for 2 cycles, ReadDataM=0xDEADBEEF in DONE, MemBe=1111.
REQ-036 Store byte 0xAB at 0x203, MemReady delayed 3 cycles -> MemBe=1000, MemWdata=0xAB000000, MemAddr=0x200, StallMemReq high for 5 cycles.
REQ-037 Load half at 0x101 -> MisalignM pulses for 1 cycle, MemValid never asserts, StallMemReq=0.
REQ-038 rst asserted during the second BUSY cycle, then MemReady pulses -> state IDLE, MemValid=0, ReadDataM=0, and no DONE cycle occurs.
REQ-039 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MemReady held low -> DONE after 4 BUSY cycles, MemError=1 and sticky, ReadDataM=0.
REQ-040 Back-to-back loads (MemReqM high in the cycle after DONE) -> a second request is issued, with exactly one IDLE cycle between the two BUSY phases.
